// File: rtl/counter_pkg.sv
// Shared types for the programmable counter: FSM state type and its encodings.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cnt_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/counter_step.sv
// Combinational next-value logic for one count step of counter_prog.
module counter_step
  import counter_pkg::*;
#(
  parameter int dw = 8
) (
  input  logic [dw-1:0] result,
  input  logic [dw-1:0] limit,
  input  logic          up,
  input  logic          oneshot,
  output logic [dw-1:0] next_val,
  output logic          term,
  output logic          clamp
);

  localparam logic [dw-1:0] ONE  = {{(dw-1){1'b0}}, 1'b1};
  localparam logic [dw-1:0] ZERO = {dw{1'b0}};

  // Step rules: a terminal event either wraps or parks at the range end.
  always_comb begin
    next_val = result;
    term     = 1'b0;
    clamp    = 1'b0;
    if (up) begin
      if (result < limit) begin
        next_val = result + ONE;
      end else begin
        term     = 1'b1;
        next_val = oneshot ? limit : ZERO;
      end
    end else begin
      if (result > limit) begin
        clamp    = 1'b1;
        next_val = limit;
      end else if (result == ZERO) begin
        term     = 1'b1;
        next_val = oneshot ? ZERO : limit;
      end else begin
        next_val = result - ONE;
      end
    end
  end

endmodule

// File: rtl/counter_prog.sv
// Programmable up/down counter with load, runtime limit, wrap/one-shot modes.
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN.
module counter_prog
  import counter_pkg::*;
#(
  parameter int dw       = 8,
  parameter int PRESCALE = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ena,
  input  logic          load,
  input  logic [dw-1:0] load_val,
  input  logic [dw-1:0] limit,
  input  logic          up,
  input  logic          oneshot,
  input  logic          start,
  output logic [dw-1:0] result,
  output logic          tc,
  output logic          busy,
  output logic          done
);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("counter_prog: PRESCALE must be >= 1");
  end

  cnt_state_t    state_r, state_n_s;
  logic [dw-1:0] result_r, result_n_s;
  logic          tc_r, tc_n_s;
  logic          busy_r, done_r;

  logic [dw-1:0] step_val_s;
  logic          step_term_s;
  logic          step_clamp_s;
  logic          run_en_s;
  logic          tick_s;

  counter_step #(.dw(dw)) u_step (
    .result   (result_r),
    .limit    (limit),
    .up       (up),
    .oneshot  (oneshot),
    .next_val (step_val_s),
    .term     (step_term_s),
    .clamp    (step_clamp_s)
  );

  // An enabled RUN cycle that is not pre-empted by a load.
  assign run_en_s = (state_r == RUN) && ena && !load;

`ifdef COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PTOP = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PONE = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0] presc_r;
  logic          leave_run_s;

  assign tick_s      = (presc_r == PTOP);
  assign leave_run_s = (state_r == RUN) && (state_n_s != RUN);

  // Prescaler: counts enabled RUN cycles, clears on load or leaving RUN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_r <= {PW{1'b0}};
    end else if (load || leave_run_s) begin
      presc_r <= {PW{1'b0}};
    end else if (run_en_s) begin
      presc_r <= tick_s ? {PW{1'b0}} : presc_r + PONE;
    end else begin
      presc_r <= presc_r;
    end
  end
`else
  assign tick_s = 1'b1;
`endif

  // Next-state / next-value: load beats counting; start only arms from IDLE/DONE.
  always_comb begin
    state_n_s  = state_r;
    result_n_s = result_r;
    tc_n_s     = 1'b0;
    if (load) begin
      result_n_s = (load_val > limit) ? limit : load_val;
    end else if (run_en_s && tick_s) begin
      result_n_s = step_val_s;
      tc_n_s     = step_term_s && !step_clamp_s;
      if (step_term_s && oneshot) begin
        state_n_s = DONE;
      end else begin
        state_n_s = state_r;
      end
    end else begin
      result_n_s = result_r;
    end
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_n_s = RUN;
        end else begin
          state_n_s = state_r;
        end
      end
      RUN: begin
        state_n_s = state_n_s;
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // State, count and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= IDLE;
      result_r <= {dw{1'b0}};
      tc_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_n_s;
      result_r <= result_n_s;
      tc_r     <= tc_n_s;
      busy_r   <= (state_n_s == RUN);
      done_r   <= (state_n_s == DONE);
    end
  end

  assign result = result_r;
  assign tc     = tc_r;
  assign busy   = busy_r;
  assign done   = done_r;

endmodule
